key_decoder: RTL and testbench

KEY_DECODER -- requirements
Module: key_decoder

---
 rtl/pong_pkg.sv | 38 +++
 rtl/key_decoder_if.sv | 30 +++
 rtl/edge_rise.sv | 34 +++
 rtl/key_decoder.sv | 157 +++++++++++++++
 tb/tb_key_decoder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and types for the keyboard front end of the pong
// controller.
//   - Key codes recognised by key_decoder.
//   - FSM state encoding for the escape-sequence tracker.
//   - Packed struct that bundles the single-cycle command pulses.
package pong_pkg;

  localparam int BYTE_W = 8;

  // Key codes (ASCII / ANSI CSI arrow keys)
  localparam logic [BYTE_W-1:0] KEY_ESC        = 8'h1B;
  localparam logic [BYTE_W-1:0] KEY_CSI        = 8'h5B;  // '[' after ESC
  localparam logic [BYTE_W-1:0] KEY_ARROW_UP   = 8'h41;  // 'A' after ESC [
  localparam logic [BYTE_W-1:0] KEY_ARROW_DOWN = 8'h42;  // 'B' after ESC [
  localparam logic [BYTE_W-1:0] KEY_SPACE      = 8'h20;
  localparam logic [BYTE_W-1:0] KEY_W_UC       = 8'h57;
  localparam logic [BYTE_W-1:0] KEY_W_LC       = 8'h77;
  localparam logic [BYTE_W-1:0] KEY_S_UC       = 8'h53;
  localparam logic [BYTE_W-1:0] KEY_S_LC       = 8'h73;
  localparam logic [BYTE_W-1:0] KEY_P_UC       = 8'h50;
  localparam logic [BYTE_W-1:0] KEY_P_LC       = 8'h70;

  // Escape-sequence tracker states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ESC  = 2'd1;
  localparam logic [1:0] ST_CSI  = 2'd2;

  // One bit per command pulse; at most one bit is ever set.
  typedef struct packed {
    logic bad_seq;
    logic start;
    logic p2_down;
    logic p2_up;
    logic p1_down;
    logic p1_up;
  } pulses_t;

endpackage

// File: rtl/key_decoder_if.sv
// key_decoder_if: byte stream from the serial receiver plus the decoded
// command outputs.
//   rx_data  [7:0] received byte, valid while rx_ready is high
//   rx_ready       receiver level, high one or more cycles per byte
//   p1_up, p1_down, p2_up, p2_down, start, bad_seq  single-cycle pulses
//   paused         pause state level (LED)
// Modports: master = byte source / command sink, slave = decoder.
interface key_decoder_if;
  import pong_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              p1_up;
  logic              p1_down;
  logic              p2_up;
  logic              p2_down;
  logic              start;
  logic              paused;
  logic              bad_seq;

  modport master (
    output rx_data, rx_ready,
    input  p1_up, p1_down, p2_up, p2_down, start, paused, bad_seq
  );

  modport slave (
    input  rx_data, rx_ready,
    output p1_up, p1_down, p2_up, p2_down, start, paused, bad_seq
  );
endinterface

// File: rtl/edge_rise.sv
// edge_rise: one-cycle pulse on a rising edge of i_in.
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_in     level input
//   o_pulse  high in the cycle where i_in=1 and the registered i_in=0
// A level that is already high across reset release is not treated as a new
// edge: detection re-arms only after i_in has been seen low.
module edge_rise (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in,
  output logic o_pulse
);

  logic r_prev;
  logic r_armed;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev  <= 1'b0;
      // Arm immediately if the line is low during reset so a byte arriving
      // on the first cycle after release is not lost.
      r_armed <= ~i_in;
    end else begin
      r_prev <= i_in;
      if (!i_in) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pulse = i_in & ~r_prev & r_armed;

endmodule

// File: rtl/key_decoder.sv
// key_decoder: turns keyboard bytes into pong commands.
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      key_decoder_if.slave (rx_data/rx_ready in, command pulses and
//            paused level out)
// Parameter TIMEOUT_CYCLES bounds the gap between bytes of an escape
// sequence; the sequence is abandoned with bad_seq when the counter reaches
// TIMEOUT_CYCLES-1.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | plain keys decoded; counter held at 0
// ST_ESC   | ESC seen, waiting for '['
// ST_CSI   | ESC [ seen, waiting for arrow code 'A' / 'B'
module key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  key_decoder_if.slave  bus
);
  import pong_pkg::*;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_paused;
  pulses_t           r_pulse;

  logic              w_accept;
  logic [BYTE_W-1:0] w_rx;
  logic [CW-1:0]     w_cnt_inc;
  logic              w_timeout;
  logic [1:0]        w_state_nxt;
  logic              w_paused_nxt;
  logic              w_cnt_clr;
  pulses_t           w_pulse;

  edge_rise u_edge_rise (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (bus.rx_ready),
    .o_pulse (w_accept)
  );

  assign w_rx      = bus.rx_data;
  assign w_cnt_inc = r_cnt + 1'b1;
  // Expires on the edge where the counter would reach CNT_LAST.
  assign w_timeout = (r_state != ST_IDLE) && (w_cnt_inc == CNT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_paused_nxt = r_paused;
    w_cnt_clr    = 1'b0;
    w_pulse      = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_rx == KEY_W_LC || w_rx == KEY_W_UC) begin
            w_pulse.p1_up = 1'b1;
          end else if (w_rx == KEY_S_LC || w_rx == KEY_S_UC) begin
            w_pulse.p1_down = 1'b1;
          end else if (w_rx == KEY_SPACE) begin
            w_pulse.start = 1'b1;
          end else if (w_rx == KEY_P_LC || w_rx == KEY_P_UC) begin
            w_paused_nxt = ~r_paused;
          end else if (w_rx == KEY_ESC) begin
            w_state_nxt = ST_ESC;
            w_cnt_clr   = 1'b1;
          end
        end
      end

      ST_ESC: begin
        // An accepted byte always wins over a coincident timeout.
        if (w_accept) begin
          if (w_rx == KEY_CSI) begin
            w_state_nxt = ST_CSI;
            w_cnt_clr   = 1'b1;
          end else if (w_rx == KEY_ESC) begin
            w_pulse.bad_seq = 1'b1;
            w_cnt_clr       = 1'b1;
          end else begin
            w_pulse.bad_seq = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_pulse.bad_seq = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end

      ST_CSI: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          if (w_rx == KEY_ARROW_UP) begin
            w_pulse.p2_up = 1'b1;
          end else if (w_rx == KEY_ARROW_DOWN) begin
            w_pulse.p2_down = 1'b1;
          end else if (w_rx == KEY_ESC) begin
            // A fresh ESC restarts tracking rather than being swallowed.
            w_pulse.bad_seq = 1'b1;
            w_state_nxt     = ST_ESC;
            w_cnt_clr       = 1'b1;
          end else begin
            w_pulse.bad_seq = 1'b1;
          end
        end else if (w_timeout) begin
          w_pulse.bad_seq = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Paddle motion is frozen while paused; everything else keeps running.
    if (r_paused) begin
      w_pulse.p1_up   = 1'b0;
      w_pulse.p1_down = 1'b0;
      w_pulse.p2_up   = 1'b0;
      w_pulse.p2_down = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_paused <= 1'b0;
      r_pulse  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_paused <= w_paused_nxt;
      r_pulse  <= w_pulse;
      if (w_state_nxt == ST_IDLE || w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.p1_up   = r_pulse.p1_up;
  assign bus.p1_down = r_pulse.p1_down;
  assign bus.p2_up   = r_pulse.p2_up;
  assign bus.p2_down = r_pulse.p2_down;
  assign bus.start   = r_pulse.start;
  assign bus.bad_seq = r_pulse.bad_seq;
  assign bus.paused  = r_paused;

endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: directed bench for key_decoder with TIMEOUT_CYCLES=20.
// Expected pulses are queued with the cycle they must appear in; a monitor
// compares the full pulse vector every cycle (zero when nothing is due).
module tb_key_decoder;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P1U    = 6'b000001;
  localparam logic [5:0] P1D    = 6'b000010;
  localparam logic [5:0] P2U    = 6'b000100;
  localparam logic [5:0] P2D    = 6'b001000;
  localparam logic [5:0] PST    = 6'b010000;
  localparam logic [5:0] PBAD   = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_decoder_if bus();

  key_decoder #(.TIMEOUT_CYCLES(20)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  exp_t       sb[$];
  exp_t       sb_head;
  int         cyc    = 0;
  int         n_vec  = 0;
  int         n_mis  = 0;
  bit         chk_en = 1'b0;
  logic [5:0] obs;
  logic [5:0] expv;
  int         c0;

  assign obs = {bus.bad_seq, bus.start, bus.p2_down, bus.p2_up,
                bus.p1_down, bus.p1_up};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      expv = P_NONE;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sb_head = sb.pop_front();
        expv    = sb_head.vec;
      end
      n_vec++;
      assert (obs === expv) else begin
        n_mis++;
        $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, obs, expv);
      end
    end
  end

  task automatic check_paused(input logic e, input string tag);
    n_vec++;
    assert (bus.paused === e) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.paused, e);
    end
  endtask

  // Called at a negedge; returns at a negedge with rx_ready low for one edge.
  task automatic send(input logic [7:0] b, input int hold, input logic [5:0] e);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    if (e != P_NONE) sb.push_back(exp_t'{cyc + 1, e});
    repeat (hold) @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check_paused(1'b0, "reset_paused");
    @(negedge clk);

    // Long-held bytes give exactly one pulse each
    send(8'h77, 16, P1U);
    send(8'h53, 16, P1D);

    // Case variants, ignored byte, start
    send(8'h61, 2, P_NONE);
    send(8'h57, 1, P1U);
    send(8'h73, 1, P1D);
    send(8'h20, 3, PST);

    // Arrow keys
    send(8'h1B, 2, P_NONE);
    send(8'h5B, 2, P_NONE);
    send(8'h41, 2, P2U);
    send(8'h1B, 2, P_NONE);
    send(8'h5B, 2, P_NONE);
    send(8'h42, 2, P2D);

    // Malformed sequences
    send(8'h1B, 1, P_NONE);
    send(8'h78, 1, PBAD);
    send(8'h77, 1, P1U);
    send(8'h1B, 1, P_NONE);
    send(8'h5B, 1, P_NONE);
    send(8'h43, 1, PBAD);
    send(8'h1B, 1, P_NONE);
    send(8'h1B, 1, PBAD);
    send(8'h5B, 1, P_NONE);
    send(8'h42, 1, P2D);

    // ESC inside CSI restarts the sequence
    send(8'h1B, 1, P_NONE);
    send(8'h5B, 1, P_NONE);
    send(8'h1B, 1, PBAD);
    send(8'h5B, 1, P_NONE);
    send(8'h42, 1, P2D);

    // Pause suppresses paddles only
    send(8'h70, 2, P_NONE);
    check_paused(1'b1, "pause_on");
    send(8'h77, 2, P_NONE);
    send(8'h1B, 1, P_NONE);
    send(8'h5B, 1, P_NONE);
    send(8'h41, 1, P_NONE);
    send(8'h20, 2, PST);
    send(8'h70, 2, P_NONE);
    check_paused(1'b0, "pause_off");
    send(8'h77, 2, P1U);
    send(8'h50, 1, P_NONE);
    check_paused(1'b1, "pause_uc_on");
    send(8'h50, 1, P_NONE);
    check_paused(1'b0, "pause_uc_off");

    // Timeout in ESC: ESC visible from cyc+1, bad_seq 19 cycles later
    bus.rx_data  = 8'h1B;
    bus.rx_ready = 1'b1;
    sb.push_back(exp_t'{cyc + 20, PBAD});
    @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (25) @(negedge clk);
    send(8'h77, 1, P1U);

    // Timeout in CSI
    send(8'h1B, 1, P_NONE);
    bus.rx_data  = 8'h5B;
    bus.rx_ready = 1'b1;
    sb.push_back(exp_t'{cyc + 20, PBAD});
    @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (25) @(negedge clk);

    // Byte accepted on the expiry edge wins over the timeout
    c0           = cyc;
    bus.rx_data  = 8'h1B;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    while (cyc < c0 + 19) @(negedge clk);
    send(8'h5B, 1, P_NONE);
    send(8'h41, 1, P2U);

    // Reset mid-sequence: no bad_seq, pause cleared, next byte plain
    send(8'h70, 1, P_NONE);
    send(8'h1B, 1, P_NONE);
    send(8'h5B, 1, P_NONE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_paused(1'b0, "reset_clears_pause");
    send(8'h41, 2, P_NONE);
    send(8'h77, 1, P1U);

    // rx_ready held high across reset release is not a new byte
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    send(8'h77, 1, P1U);

    repeat (3) @(negedge clk);
    n_vec++;
    assert (sb.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_drained observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
